pipe_in_check: RTL
==================

Name: pipe_in_check

Overview:
Sink-side checker for Pipe In verification. It accepts 16-bit words from the host pipe and regenerates the same pseudorandom or count sequence the Pipe Out generator produces. Each received word is compared against the expected value, and the checker reports error counts, first-mismatch details and word totals. It models a virtual receive FIFO drained by a circular throttle register, and derives pipe_in_ready from that FIFO.

Parameters:
LEVEL_MAX, 16'd65535, virtual FIFO capacity in words.
READY_SPACE, 16'd1024, free space required for pipe_in_ready to assert.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
pipe_in_write  input  1  host write strobe; one word per high cycle
pipe_in_data  input  16  host data, valid when pipe_in_write=1
pipe_in_ready  output  1  registered; space for a READY_SPACE-word block
throttle_set  input  1  loads throttle_val into throttle register
throttle_val  input  32  drain pattern; also loaded at reset
mode  input  1  0=count, 1=LFSR; sampled only while reset=1
error_count  output  32  mismatching words, saturates at 32'hFFFFFFFF
error_flag  output  1  sticky, set on first mismatch
word_count  output  32  words received, wraps modulo 2^32
first_err_index  output  32  word_count value of the first mismatching word
first_err_expected  output  16  expected value at first mismatch
first_err_received  output  16  received value at first mismatch
overflow  output  1  sticky, write seen while level==LEVEL_MAX

Behaviour:
- Reset:
  - All outputs are 0.
  - level=0; throttle=throttle_val; mode latched into mode_q.
  - Generator seed: mode 1 loads 64'h0D0C0B0A04030201; mode 0 loads 64'h0000000100000001.
- Expected word is always gen[15:0].
- On a cycle with pipe_in_write=1:
  - data is compared to gen[15:0];
  - word_count increments;
  - the generator advances.
  - All results are visible the cycle after the write, i.e. 1-cycle latency.
- Generator advance:
  - mode_q=1: each 32-bit half r shifts left one bit, with new bit0 = r[31]^r[21]^r[1].
  - mode_q=0: each 32-bit half increments by 1.
  - Halves are independent.
  - The generator never advances without a write.
- Mismatch handling:
  - error_count increments, saturating.
  - If error_flag=0: set error_flag and capture first_err_index (the pre-increment word_count), expected and received. Later mismatches do not update the captures.
- Throttle:
  - If throttle_set=1, throttle loads throttle_val and does not rotate that cycle.
  - Otherwise throttle rotates right: {t[0],t[31:1]}.
  - A drain occurs when throttle[0]=1, evaluated before the update.
- Virtual level, keyed on {write, drain}:
  - 00: no change.
  - 10: +1, saturating at LEVEL_MAX; set overflow if already at LEVEL_MAX.
  - 01: -1 if level>0, else no change.
  - 11: no change.
- pipe_in_ready is registered: 1 when (LEVEL_MAX - level) >= READY_SPACE, computed in 17 bits, else 0. It lags level by one cycle.
- Writes while pipe_in_ready=0 are still checked and counted; the host is responsible for block flow control.
- Mode changes outside reset are ignored.
- Reset asserted mid-stream: on the next edge it clears all counters, sticky flags and captures, and reseeds the generator.

Test Plan:
1. Reset with mode=0, throttle_val=32'hFFFFFFFF; write 0x0001, 0x0002, 0x0003 -> word_count=3, error_count=0, error_flag=0.
2. Reset with mode=1; write 0x0201 then 0x0402 -> error_count=0. A third write of 0x0000 -> error_flag=1, error_count=1, first_err_index=2, first_err_received=0x0000, first_err_expected equal to the LFSR's next value.
3. After a first error, inject further mismatches -> error_count increments; first_err_* fields unchanged.
4. Readiness with throttle_val=0: reset -> pipe_in_ready=1. After 64512 writes -> level=64512, pipe_in_ready=1. After 64513 writes -> pipe_in_ready=0 one cycle later.
5. Fill to LEVEL_MAX with throttle_val=0, then write once more -> level stays 65535 and overflow=1. Then throttle_set with 32'h00000001 -> level drains by 1 every 32 cycles.
6. Assert reset mid-stream in mode 1 with error_flag=1 -> all outputs 0 next cycle; expected word sequence restarts at 0x0201.

Source files
------------

// File: rtl/pipe_in_check.sv
// rtl/pipe_in_check.sv - Pipe In sink checker: regenerates the expected stream and tracks errors and FIFO level

// Generates the expected 16-bit word sequence as two independent 32-bit
// halves. The mode is latched during reset and held until the next reset.
module pipe_in_check_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mode,
    input  logic        i_advance,
    output logic [15:0] o_word
);

    logic        r_mode_q;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    function automatic logic [31:0] f_lfsr(input logic [31:0] r);
        return {r[30:0], r[31] ^ r[21] ^ r[1]};
    endfunction

    // Seed on reset; step both halves only when a word is consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q <= i_mode;
            if (i_mode) begin
                r_hi <= 32'h0D0C0B0A;
                r_lo <= 32'h04030201;
            end else begin
                r_hi <= 32'h00000001;
                r_lo <= 32'h00000001;
            end
        end else if (i_advance) begin
            if (r_mode_q) begin
                r_hi <= f_lfsr(r_hi);
                r_lo <= f_lfsr(r_lo);
            end else begin
                r_hi <= r_hi + 32'd1;
                r_lo <= r_lo + 32'd1;
            end
        end
    end

    assign o_word = r_lo[15:0];

endmodule

// Top-level checker.
module pipe_in_check #(
    parameter logic [15:0] LEVEL_MAX   = 16'd65535,
    parameter logic [15:0] READY_SPACE = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_in_write,
    input  logic [15:0] pipe_in_data,
    output logic        pipe_in_ready,
    input  logic        throttle_set,
    input  logic [31:0] throttle_val,
    input  logic        mode,
    output logic [31:0] error_count,
    output logic        error_flag,
    output logic [31:0] word_count,
    output logic [31:0] first_err_index,
    output logic [15:0] first_err_expected,
    output logic [15:0] first_err_received,
    output logic        overflow
);

    logic [15:0] w_expected;
    logic        w_mismatch;
    logic        w_drain;
    logic        w_ready_next;

    logic [31:0] r_throttle;
    logic [15:0] r_level;
    logic        r_ready;
    logic [31:0] r_error_count;
    logic        r_error_flag;
    logic [31:0] r_word_count;
    logic [31:0] r_first_err_index;
    logic [15:0] r_first_err_expected;
    logic [15:0] r_first_err_received;
    logic        r_overflow;

    pipe_in_check_gen u_gen (
        .clk       (clk),
        .reset     (reset),
        .i_mode    (mode),
        .i_advance (pipe_in_write),
        .o_word    (w_expected)
    );

    assign w_mismatch = pipe_in_write && (pipe_in_data != w_expected);
    assign w_drain    = r_throttle[0];

    // Free space is computed one bit wider so the subtraction can never wrap
    assign w_ready_next = (({1'b0, LEVEL_MAX} - {1'b0, r_level}) >= {1'b0, READY_SPACE});

    // Circular drain pattern: load on request, otherwise rotate right
    always_ff @(posedge clk) begin
        if (reset) begin
            r_throttle <= throttle_val;
        end else if (throttle_set) begin
            r_throttle <= throttle_val;
        end else begin
            r_throttle <= {r_throttle[0], r_throttle[31:1]};
        end
    end

    // Virtual receive FIFO level; a simultaneous write and drain cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level    <= 16'd0;
            r_overflow <= 1'b0;
        end else begin
            case ({pipe_in_write, w_drain})
                2'b10: begin
                    if (r_level == LEVEL_MAX) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_level <= r_level + 16'd1;
                    end
                end
                2'b01: begin
                    if (r_level != 16'd0) begin
                        r_level <= r_level - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Ready reflects the level of the previous cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
        end
    end

    // Word counting, saturating error count and first-mismatch capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_count         <= 32'd0;
            r_error_count        <= 32'd0;
            r_error_flag         <= 1'b0;
            r_first_err_index    <= 32'd0;
            r_first_err_expected <= 16'd0;
            r_first_err_received <= 16'd0;
        end else if (pipe_in_write) begin
            r_word_count <= r_word_count + 32'd1;
            if (w_mismatch) begin
                if (r_error_count != 32'hFFFFFFFF) begin
                    r_error_count <= r_error_count + 32'd1;
                end
                if (!r_error_flag) begin
                    r_error_flag         <= 1'b1;
                    r_first_err_index    <= r_word_count;
                    r_first_err_expected <= w_expected;
                    r_first_err_received <= pipe_in_data;
                end
            end
        end
    end

    assign pipe_in_ready      = r_ready;
    assign error_count        = r_error_count;
    assign error_flag         = r_error_flag;
    assign word_count         = r_word_count;
    assign first_err_index    = r_first_err_index;
    assign first_err_expected = r_first_err_expected;
    assign first_err_received = r_first_err_received;
    assign overflow           = r_overflow;

endmodule
